// File: rtl/washer_plant_model.sv
// Plant/sensor emulator for the washing-machine controller: turns actuator
// commands into tank level, door and timer sensors, and latches illegal combos.
module washer_plant_model #(
    parameter int LEVEL_MAX   = 8,
    parameter int LEVEL_W     = 4,
    parameter int DET_CYCLES  = 3,
    parameter int WASH_CYCLES = 10,
    parameter int SPIN_CYCLES = 6,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               door_req,
    input  logic               fillvalve_on,
    input  logic               drainvalve_on,
    input  logic               motor_on,
    input  logic               doorlock,
    input  logic               soap_wash,
    input  logic               water_wash,
    input  logic               done,
    output logic               doorclose,
    output logic               filled,
    output logic               drained,
    output logic               detergent,
    output logic               cycletime_out,
    output logic               spintime_out,
    output logic [LEVEL_W-1:0] water_level,
    output logic [2:0]         fault
);

    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(LEVEL_MAX);
    localparam logic [CNT_W-1:0]   DET_TOP   = CNT_W'(DET_CYCLES);
    localparam logic [CNT_W-1:0]   WASH_TOP  = CNT_W'(WASH_CYCLES);
    localparam logic [CNT_W-1:0]   SPIN_TOP  = CNT_W'(SPIN_CYCLES);

    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [CNT_W-1:0]   det_cnt_reg, det_cnt_next;
    logic [CNT_W-1:0]   wash_cnt_reg, wash_cnt_next;
    logic [CNT_W-1:0]   spin_cnt_reg, spin_cnt_next;
    logic               doorclose_reg, doorclose_next;
    logic               detergent_reg, detergent_next;
    logic               soap_prev_reg, water_prev_reg;
    logic [2:0]         fault_reg;
    logic [2:0]         fault_hit;
    logic               both_valves;
    logic               phase_change;
    logic               wash_qual;

    assign both_valves  = fillvalve_on && drainvalve_on;
    // Soap phase ending on the same edge the rinse phase starts restarts the wash timer.
    assign phase_change = soap_prev_reg && !soap_wash && !water_prev_reg && water_wash;
    assign wash_qual    = motor_on && filled && (soap_wash || water_wash);

    assign filled        = (level_reg == LEVEL_TOP);
    assign drained       = (level_reg == '0);
    assign cycletime_out = (wash_cnt_reg == WASH_TOP);
    assign spintime_out  = (spin_cnt_reg == SPIN_TOP);
    assign water_level   = level_reg;
    assign doorclose     = doorclose_reg;
    assign detergent     = detergent_reg;
    assign fault         = fault_reg;

    always_comb begin
        level_next = level_reg;
        if (fillvalve_on && !drainvalve_on && (level_reg < LEVEL_TOP)) begin
            level_next = level_reg + 1'b1;
        end else if (drainvalve_on && !fillvalve_on && (level_reg != '0)) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_comb begin
        doorclose_next = doorlock ? doorclose_reg : door_req;
    end

    always_comb begin
        det_cnt_next   = det_cnt_reg;
        detergent_next = detergent_reg;
        if (done) begin
            det_cnt_next   = '0;
            detergent_next = 1'b0;
        end else begin
            if (det_cnt_reg == DET_TOP) begin
                detergent_next = 1'b1;
            end
            if (soap_wash && filled && (det_cnt_reg < DET_TOP)) begin
                det_cnt_next = det_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        wash_cnt_next = wash_cnt_reg;
        if (!motor_on || phase_change) begin
            wash_cnt_next = '0;
        end else if (wash_qual && (wash_cnt_reg < WASH_TOP)) begin
            wash_cnt_next = wash_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        spin_cnt_next = spin_cnt_reg;
        if (!motor_on) begin
            spin_cnt_next = '0;
        end else if (drainvalve_on && drained && (spin_cnt_reg < SPIN_TOP)) begin
            spin_cnt_next = spin_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg      <= '0;
            det_cnt_reg    <= '0;
            wash_cnt_reg   <= '0;
            spin_cnt_reg   <= '0;
            doorclose_reg  <= 1'b0;
            detergent_reg  <= 1'b0;
            soap_prev_reg  <= 1'b0;
            water_prev_reg <= 1'b0;
        end else begin
            level_reg      <= level_next;
            det_cnt_reg    <= det_cnt_next;
            wash_cnt_reg   <= wash_cnt_next;
            spin_cnt_reg   <= spin_cnt_next;
            doorclose_reg  <= doorclose_next;
            detergent_reg  <= detergent_next;
            soap_prev_reg  <= soap_wash;
            water_prev_reg <= water_wash;
        end
    end

    // Fault flags are observation only; nothing above reads them back.
    assign fault_hit[0] = both_valves;
    assign fault_hit[1] = motor_on && !doorclose_reg;
    assign fault_hit[2] = fillvalve_on && !doorlock;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fault
            always_ff @(posedge clk) begin
                if (rst) begin
                    fault_reg[gi] <= 1'b0;
                end else if (fault_hit[gi]) begin
                    fault_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_washer_plant_model.sv
// Closed-loop-free bench for washer_plant_model: directed plan with literal
// expectations, then randomized commands checked every cycle against a model.
module tb_washer_plant_model;

    localparam int LMAX = 8;
    localparam int DETC = 3;
    localparam int WASHC = 10;
    localparam int SPINC = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic door_req = 1'b0, fillvalve_on = 1'b0, drainvalve_on = 1'b0, motor_on = 1'b0;
    logic doorlock = 1'b0, soap_wash = 1'b0, water_wash = 1'b0, done = 1'b0;
    logic doorclose, filled, drained, detergent, cycletime_out, spintime_out;
    logic [3:0] water_level;
    logic [2:0] fault;

    int checks = 0;
    int errors = 0;

    washer_plant_model #(
        .LEVEL_MAX(LMAX), .LEVEL_W(4), .DET_CYCLES(DETC),
        .WASH_CYCLES(WASHC), .SPIN_CYCLES(SPINC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .door_req(door_req), .fillvalve_on(fillvalve_on),
        .drainvalve_on(drainvalve_on), .motor_on(motor_on), .doorlock(doorlock),
        .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
        .doorclose(doorclose), .filled(filled), .drained(drained),
        .detergent(detergent), .cycletime_out(cycletime_out),
        .spintime_out(spintime_out), .water_level(water_level), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference plant: integer level and timers, advanced once per rising edge.
    int  m_level, m_det, m_wash, m_spin;
    bit  m_door, m_detg, m_ps, m_pw, armed;
    bit  [2:0] m_fault;

    always @(posedge clk) begin
        bit full, empty;
        full  = (m_level == LMAX);
        empty = (m_level == 0);
        if (rst) begin
            m_level = 0; m_det = 0; m_wash = 0; m_spin = 0;
            m_door = 0; m_detg = 0; m_ps = 0; m_pw = 0; m_fault = 0;
            armed = 1;
        end else begin
            if (fillvalve_on && drainvalve_on) m_fault[0] = 1;
            if (motor_on && !m_door)           m_fault[1] = 1;
            if (fillvalve_on && !doorlock)     m_fault[2] = 1;

            if (fillvalve_on && !drainvalve_on)      m_level = (m_level < LMAX) ? m_level + 1 : LMAX;
            else if (drainvalve_on && !fillvalve_on) m_level = (m_level > 0) ? m_level - 1 : 0;

            if (done) begin
                m_det = 0; m_detg = 0;
            end else begin
                if (m_det == DETC) m_detg = 1;
                if (soap_wash && full) m_det = (m_det < DETC) ? m_det + 1 : DETC;
            end

            if (!motor_on || (m_ps && !soap_wash && !m_pw && water_wash)) m_wash = 0;
            else if (full && (soap_wash || water_wash)) m_wash = (m_wash < WASHC) ? m_wash + 1 : WASHC;

            if (!motor_on) m_spin = 0;
            else if (drainvalve_on && empty) m_spin = (m_spin < SPINC) ? m_spin + 1 : SPINC;

            if (!doorlock) m_door = door_req;
            m_ps = soap_wash;
            m_pw = water_wash;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("level", water_level, m_level);
            chk("filled", filled, m_level == LMAX);
            chk("drained", drained, m_level == 0);
            chk("doorclose", doorclose, m_door);
            chk("detergent", detergent, m_detg);
            chk("cycletime_out", cycletime_out, m_wash == WASHC);
            chk("spintime_out", spintime_out, m_spin == SPINC);
            chk("fault", fault, m_fault);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk("rst_doorclose", doorclose, 0);
        chk("rst_drained", drained, 1);
        chk("rst_filled", filled, 0);
        chk("rst_level", water_level, 0);
        chk("rst_fault", fault, 0);

        door_req = 1'b1;
        cyc(1);
        chk("door_closed", doorclose, 1);
        doorlock = 1'b1; fillvalve_on = 1'b1;
        for (int i = 1; i <= LMAX; i++) begin
            cyc(1);
            chk("fill_step", water_level, i);
        end
        chk("fill_full", filled, 1);
        cyc(2);
        chk("fill_hold", water_level, LMAX);
        fillvalve_on = 1'b0;

        drainvalve_on = 1'b1;
        cyc(3);
        chk("drain_to5", water_level, 5);
        fillvalve_on = 1'b1;
        cyc(3);
        chk("both_hold", water_level, 5);
        chk("both_fault", fault[0], 1);
        fillvalve_on = 1'b0; drainvalve_on = 1'b0;
        cyc(1);
        chk("both_sticky", fault[0], 1);

        fillvalve_on = 1'b1;
        cyc(3);
        fillvalve_on = 1'b0;
        chk("refill", water_level, LMAX);

        soap_wash = 1'b1; motor_on = 1'b1;
        cyc(3);
        chk("det_early", detergent, 0);
        cyc(1);
        chk("det_on", detergent, 1);
        cyc(5);
        chk("wash_early", cycletime_out, 0);
        cyc(1);
        chk("wash_done", cycletime_out, 1);
        motor_on = 1'b0;
        cyc(1);
        chk("wash_clear", cycletime_out, 0);

        soap_wash = 1'b0; motor_on = 1'b1; drainvalve_on = 1'b1;
        cyc(LMAX);
        chk("drain_empty", drained, 1);
        cyc(SPINC - 1);
        chk("spin_early", spintime_out, 0);
        cyc(1);
        chk("spin_done", spintime_out, 1);
        done = 1'b1;
        cyc(1);
        chk("done_det", detergent, 0);
        done = 1'b0; motor_on = 1'b0; drainvalve_on = 1'b0;

        door_req = 1'b0;
        cyc(2);
        chk("lock_hold", doorclose, 1);
        doorlock = 1'b0;
        cyc(1);
        chk("unlock_open", doorclose, 0);
        motor_on = 1'b1;
        cyc(1);
        chk("motor_fault", fault, 3'b011);
        motor_on = 1'b0;

        // Random phase: valves and motor biased so the tank actually cycles.
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            door_req      = ($urandom_range(0, 3) != 0);
            doorlock      = ($urandom_range(0, 3) != 0);
            fillvalve_on  = ($urandom_range(0, 2) == 0);
            drainvalve_on = ($urandom_range(0, 2) == 0);
            motor_on      = ($urandom_range(0, 4) != 0);
            soap_wash     = ($urandom_range(0, 1) == 0);
            water_wash    = ($urandom_range(0, 1) == 0);
            done          = ($urandom_range(0, 39) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
